// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a 1-cycle-latency byte FIFO onto an 8-bit UART line (start, 8 data LSB first, optional even parity, stop)
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) state_d = S_WAIT;
            end
            S_WAIT: begin
                // FIFO data becomes valid the cycle after the pop strobe
                shift_d  = fifo_data;
                parity_d = ^fifo_data;
                baud_d   = '0;
                state_d  = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_PARITY, S_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = (state_q == S_PARITY) ? S_STOP : S_IDLE;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level follows the state being entered so tx changes on the bit's first edge
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    assign fifo_rd    = !rst && (state_q == S_IDLE) && enable && !fifo_empty;
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx with behavioural FIFO and frame model
module tb_fifo_uart_tx;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, en0, en1;
    logic       rd0, rd1, tx0, tx1, busy0, busy1, fd0, fd1;
    logic       empty0, empty1;
    logic [7:0] fdata0 = 8'd0, fdata1 = 8'd0;
    logic [7:0] mem0 [0:63];
    logic [7:0] mem1 [0:63];
    int         wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    logic       sel;
    int         checks = 0;
    int         errors = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .enable(en0), .fifo_empty(empty0), .fifo_data(fdata0),
        .fifo_rd(rd0), .tx(tx0), .busy(busy0), .frame_done(fd0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .enable(en1), .fifo_empty(empty1), .fifo_data(fdata1),
        .fifo_rd(rd1), .tx(tx1), .busy(busy1), .frame_done(fd1)
    );

    // Behavioural sync_fifo: registered read data one cycle after the pop
    assign empty0 = (wp0 == rp0);
    assign empty1 = (wp1 == rp1);
    always @(posedge clk) begin
        if (rd0) begin
            fdata0 <= mem0[rp0[5:0]];
            rp0    <= rp0 + 1;
        end
        if (rd1) begin
            fdata1 <= mem1[rp1[5:0]];
            rp1    <= rp1 + 1;
        end
    end

    logic tx_m, rd_m, busy_m, fd_m, empty_m;
    assign tx_m    = sel ? tx1    : tx0;
    assign rd_m    = sel ? rd1    : rd0;
    assign busy_m  = sel ? busy1  : busy0;
    assign fd_m    = sel ? fd1    : fd0;
    assign empty_m = sel ? empty1 : empty0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic which, input logic [7:0] b);
        if (which) begin
            mem1[wp1[5:0]] = b;
            wp1++;
            exp1.push_back(b);
        end else begin
            mem0[wp0[5:0]] = b;
            wp0++;
            exp0.push_back(b);
        end
    endtask

    // Called in the cycle where fifo_rd is high; walks WAIT plus every bit of the frame
    task automatic check_frame(input int drop_at);
        logic [7:0]  b;
        logic [15:0] bits;
        int          nb, busy_cnt, cyc;
        b = sel ? exp1.pop_front() : exp0.pop_front();
        nb = sel ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
        if (sel) bits[9] = ^b;
        busy_cnt = 0;
        @(negedge clk);
        check("wait_rd", rd_m, 0);
        check("wait_tx", tx_m, 1);
        busy_cnt += busy_m;
        cyc = 1;
        for (int bi = 0; bi < nb; bi++) begin
            for (int c = 0; c < N; c++) begin
                @(negedge clk);
                if (cyc == drop_at) begin
                    if (sel) en1 = 1'b0; else en0 = 1'b0;
                end
                check("tx_bit", tx_m, bits[bi]);
                check("frame_done", fd_m, (bi == nb - 1) && (c == N - 1));
                check("rd_in_frame", rd_m, 0);
                busy_cnt += busy_m;
                cyc++;
            end
        end
        @(negedge clk);
        check("busy_end", busy_m, 0);
        check("busy_cycles", busy_cnt, 1 + nb * N);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b1; en1 = 1'b0; sel = 1'b0;
        push(1'b0, 8'h9B);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx", tx0, 1);
            check("rst_rd", rd0, 0);
            check("rst_busy", busy0, 0);
        end
        rst0 = 1'b0; rst1 = 1'b0;
        #1;
        check("first_rd", rd0, 1);
        check_frame(-1);
        check("idle_empty_rd", rd0, 0);

        // Parity frames on dut1: fixed 0xDA, then random bytes back-to-back
        sel = 1'b1;
        en1 = 1'b1;
        push(1'b1, 8'hDA);
        for (int i = 0; i < 4; i++) push(1'b1, 8'($urandom));
        #1;
        for (int i = 0; i < 5; i++) begin
            check("par_rd", rd1, 1);
            check_frame(-1);
        end
        check("par_drained", empty1, 1);

        // Burst on dut0 with fixed pop spacing
        sel = 1'b0;
        en0 = 1'b0;
        push(1'b0, 8'd1); push(1'b0, 8'd2); push(1'b0, 8'd3); push(1'b0, 8'd4);
        push(1'b0, 8'd5); push(1'b0, 8'd155); push(1'b0, 8'd218); push(1'b0, 8'd60);
        @(negedge clk);
        en0 = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("burst_rd_spacing", rd0, 1);
            check_frame(-1);
        end
        check("burst_empty", empty0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_burst_rd", rd0, 0);
            check("post_burst_tx", tx0, 1);
        end

        // Enable gating, then enable dropped mid-DATA
        en0 = 1'b0;
        push(1'b0, 8'($urandom)); push(1'b0, 8'($urandom));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("en_off_rd", rd0, 0);
            check("en_off_busy", busy0, 0);
        end
        en0 = 1'b1;
        #1;
        check("en_on_rd", rd0, 1);
        check_frame(1 + N + 3 * N);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("en_drop_rd", rd0, 0);
        end
        check("en_drop_left", wp0 - rp0, 1);

        // Reset during data bit 3
        push(1'b0, 8'($urandom));
        en0 = 1'b1;
        #1;
        check("rstmid_rd", rd0, 1);
        void'(exp0.pop_front());
        repeat (1 + N + 3 * N + 2) @(negedge clk);
        rst0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstmid_tx", tx0, 1);
            check("rstmid_busy", busy0, 0);
            check("rstmid_fd", fd0, 0);
            check("rstmid_rd", rd0, 0);
            check("rstmid_left", wp0 - rp0, 1);
        end
        rst0 = 1'b0;
        #1;
        check("rstmid_resume_rd", rd0, 1);
        check_frame(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for sync_fifo. It pops bytes from the FIFO read port and serialises each one as an asynchronous UART frame on a single output line. Framing is start bit, 8 data bits LSB first, an optional even parity bit, and one stop bit. It sits between the byte FIFO and the board-level TX pin, and is the FIFO's only reader.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
PARITY_EN, 0, 0 = no parity bit; 1 = even parity bit inserted between the last data bit and the stop bit.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  permits starting a new frame; sampled only in IDLE.
fifo_empty  input  1  connects to the FIFO empty output.
fifo_data  input  8  connects to the FIFO data_out.
fifo_rd  output  1  connects to the FIFO rd input; single-cycle pop strobe.
tx  output  1  serial line; idles high; registered.
busy  output  1  high whenever state != IDLE.
frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high, on rst.
  - While rst is high, the next edge forces: state IDLE, tx = 1, fifo_rd = 0, busy = 0, frame_done = 0, baud counter = 0, bit counter = 0, shift register = 0.
- FIFO read contract:
  - sync_fifo has a 1-cycle read latency.
  - fifo_rd is high during cycle k, so the pop happens at the edge ending cycle k.
  - fifo_data is valid during cycle k+1 and is latched at the end of that cycle.
- States: IDLE, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - tx = 1.
  - fifo_rd = enable && !fifo_empty, driven combinationally from state and inputs.
  - If that condition holds, the next state is WAIT; otherwise stay in IDLE.
- WAIT (exactly 1 cycle):
  - fifo_rd = 0.
  - Shift register <= fifo_data.
  - Parity bit <= XOR of fifo_data.
  - Next state is START, baud counter = 0.
  - fifo_empty is ignored in this state.
- START:
  - tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index.
  - After bit index 7, go to PARITY if PARITY_EN = 1, otherwise to STOP.
- PARITY:
  - tx = stored parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx = 1 for CLKS_PER_BIT cycles.
  - frame_done = 1 in the final cycle of the stop bit.
  - Then go to IDLE.
- tx timing:
  - tx is a registered output; it changes on the edge that enters each bit.
  - Each bit therefore occupies exactly CLKS_PER_BIT cycles on the line.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Counts 0 to CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Back-to-back frames:
  - IDLE always lasts at least 1 cycle.
  - With FIFO data available and enable high, the period from one fifo_rd pulse to the next is (10 + PARITY_EN) * CLKS_PER_BIT + 2 cycles.
- Enable:
  - Deasserting enable mid-frame has no effect; the current frame completes.
  - New frames start only when enable is high in IDLE.
- Empty FIFO:
  - In IDLE with fifo_empty = 1, fifo_rd stays 0 and tx stays 1 indefinitely.
  - The block never issues a read while the FIFO is empty.
- Reset mid-frame:
  - The frame is aborted and tx returns to 1 on the next edge.
  - The byte already popped is discarded; no further read is issued.
- fifo_rd pulse width:
  - fifo_rd is never high for two consecutive cycles.

Test Plan:
1. Reset: hold rst = 1 for 3 cycles with fifo_empty = 0 and enable = 1 -> tx = 1, fifo_rd = 0, busy = 0 throughout; after release, the first fifo_rd is seen in the first cycle.
2. Single byte, CLKS_PER_BIT = 4, PARITY_EN = 0: FIFO holds 155 (0x9B).
   - Required: fifo_rd is a 1-cycle pulse.
   - Then, after the WAIT cycle, tx = 0 for 4 cycles.
   - Then data 1,1,0,1,1,0,0,1 at 4 cycles each.
   - Then stop = 1 for 4 cycles, with frame_done pulsed in the final stop cycle.
   - busy = 1 for 41 cycles.
3. Parity, CLKS_PER_BIT = 4, PARITY_EN = 1: byte 218 (0xDA).
   - Required: data bits 0,1,0,1,1,0,1,1, then parity bit = 1, then stop.
   - Frame is 44 cycles of start/data/parity/stop.
4. Burst: write 1,2,3,4,5,155,218,60 into sync_fifo via its wr port, enable = 1, CLKS_PER_BIT = 4.
   - Required: 8 frames decoded in order by a bench UART monitor.
   - fifo_rd pulses spaced exactly 42 cycles apart.
   - fifo_empty = 1 after the 8th pop.
   - tx idles high afterwards with no extra fifo_rd.
5. Enable/empty gating:
   - enable = 0 with a non-empty FIFO -> no fifo_rd.
   - Deassert enable in the middle of the DATA state -> the frame completes, then no further pop.
6. Reset mid-frame: assert rst during data bit 3 -> tx = 1 and busy = 0 on the next edge, frame_done is never pulsed, and the remaining FIFO contents are untouched until reset is released.
